sha256_msg_padder: RTL and testbench

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/data_masker.sv | 25 ++
 rtl/sha256_msg_padder.sv | 142 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared constants and state type for the SHA-256 message
//                padder block.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    localparam int         WORDS_PER_BLOCK = 8;
    localparam int         LEN_W           = 64;
    localparam logic [7:0] PAD_BYTE        = 8'h80;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_masker.sv
`default_nettype none
// ============================================================================
//  Module      : data_masker
//  Description : Zeroes the padbytes_i least-significant bytes of a word when
//                enabled; passes the word through unchanged otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_masker #(
    parameter  int width_p = 64,
    localparam int PB_W    = $clog2(width_p / 8)
) (
    input  logic [width_p-1:0] data_i,
    input  logic [PB_W-1:0]    padbytes_i,
    input  logic               en_i,
    output logic [width_p-1:0] data_o
);

    // Byte b (counted from the LSB) is invalid when b < padbytes_i.
    for (genvar b = 0; b < width_p / 8; b++) begin : g_byte
        assign data_o[8*b +: 8] = (en_i && (PB_W'(b) < padbytes_i)) ? 8'h00
                                                                    : data_i[8*b +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_padder
//  Description : Packs 64-bit big-endian message words into 512-bit blocks and
//                applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit
//                length). Emits an extra block when the length does not fit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int width_p   = 64,
    parameter int block_w_p = 512
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [width_p-1:0]   data_i,
    input  logic [2:0]           padbytes_i,
    input  logic                 last_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [block_w_p-1:0] block_o,
    output logic                 block_valid_o,
    input  logic                 block_ready_i,
    output logic                 block_last_o
);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_extra_pending;
    logic             r_extra_pad;
    logic             r_last;
    logic [63:0]      r_slot [WORDS_PER_BLOCK];

    logic             w_accept;
    logic [63:0]      w_masked;
    logic [63:0]      w_pad_mask;
    logic [63:0]      w_word;
    logic [LEN_W-1:0] w_len_next;
    logic             w_fits;
    logic [2:0]       w_cnt_inc;

    data_masker #(
        .width_p    (64)
    ) u_masker (
        .data_i     (data_i),
        .padbytes_i (padbytes_i),
        .en_i       (last_i),
        .data_o     (w_masked)
    );

    // Word acceptance, 0x80 insertion inside the word, length and fit tests.
    always_comb begin
        w_accept   = valid_i && (r_state == S_FILL);
        w_pad_mask = {56'b0, PAD_BYTE} << {padbytes_i - 3'd1, 3'b000};
        w_word     = w_masked;
        if (last_i && (padbytes_i != 3'd0)) begin
            w_word = w_masked | w_pad_mask;
        end
        w_len_next = r_len + (last_i ? (64'd64 - {58'b0, padbytes_i, 3'b000}) : 64'd64);
        w_fits     = (r_cnt <= 3'd5) || ((r_cnt == 3'd6) && (padbytes_i != 3'd0));
        w_cnt_inc  = r_cnt + 3'd1;
    end

    // Fill/send state machine with block assembly.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state         <= S_FILL;
            r_cnt           <= 3'd0;
            r_len           <= '0;
            r_extra_pending <= 1'b0;
            r_extra_pad     <= 1'b0;
            r_last          <= 1'b0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_slot[r_cnt] <= w_word;
                        r_cnt         <= w_cnt_inc;
                        r_len         <= w_len_next;
                        if (last_i) begin
                            // Marker lands in the next slot when the last word is full.
                            if ((padbytes_i == 3'd0) && (r_cnt != 3'd7)) begin
                                r_slot[w_cnt_inc] <= {PAD_BYTE, 56'b0};
                            end
                            if (w_fits) begin
                                r_slot[7] <= w_len_next;
                                r_last    <= 1'b1;
                            end else begin
                                r_extra_pending <= 1'b1;
                                r_extra_pad     <= (padbytes_i == 3'd0) && (r_cnt == 3'd7);
                            end
                            r_state <= S_SEND;
                        end else if (r_cnt == 3'd7) begin
                            r_state <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (block_ready_i) begin
                        if (r_extra_pending) begin
                            for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) begin
                                r_slot[i] <= '0;
                            end
                            r_slot[0]       <= r_extra_pad ? {PAD_BYTE, 56'b0} : 64'd0;
                            r_slot[7]       <= r_len;
                            r_last          <= 1'b1;
                            r_extra_pending <= 1'b0;
                            r_extra_pad     <= 1'b0;
                        end else begin
                            r_state <= S_FILL;
                            r_cnt   <= 3'd0;
                            r_last  <= 1'b0;
                            if (r_last) begin
                                r_len <= '0;
                            end
                            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                                r_slot[i] <= '0;
                            end
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    // Slot k maps to the k-th 64-bit field from the top of the block.
    for (genvar k = 0; k < WORDS_PER_BLOCK; k++) begin : g_slot
        assign block_o[block_w_p-1-64*k -: 64] = r_slot[k];
    end

    assign ready_o       = (r_state == S_FILL);
    assign block_valid_o = (r_state == S_SEND);
    assign block_last_o  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_msg_padder
//  Description : Self-checking bench for sha256_msg_padder. Expected blocks
//                come from a byte-level SHA-256 padding model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  data;
    logic [2:0]   padbytes;
    logic         last;
    logic         valid;
    logic         ready;
    logic [511:0] blk;
    logic         bvalid;
    logic         bready;
    logic         blast;

    int tests = 0;
    int fails = 0;

    byte unsigned msg[$];
    logic [511:0] exp_blocks[$];

    always #5 clk = ~clk;

    sha256_msg_padder #(
        .width_p       (64),
        .block_w_p     (512)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .data_i        (data),
        .padbytes_i    (padbytes),
        .last_i        (last),
        .valid_i       (valid),
        .ready_o       (ready),
        .block_o       (blk),
        .block_valid_o (bvalid),
        .block_ready_i (bready),
        .block_last_o  (blast)
    );

    task automatic check_blk(string tag, logic [511:0] obs, logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Standard SHA-256 padding of the whole byte message, split into 64-byte blocks.
    function automatic void build_expected();
        byte unsigned p[$];
        logic [63:0]  bits;
        logic [511:0] v;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_blocks.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            v = '0;
            for (int j = 0; j < 64; j++) v[511-8*j -: 8] = p[64*b+j];
            exp_blocks.push_back(v);
        end
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        valid  = 1'b0;
        last   = 1'b0;
        bready = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
    endtask

    // Drive n full non-last words of random data, one per cycle.
    task automatic drive_words(int n);
        for (int i = 0; i < n; i++) begin
            data     = {$urandom, $urandom};
            padbytes = 3'($urandom);
            last     = 1'b0;
            valid    = 1'b1;
            check_bit("pre_ready", ready, 1'b1);
            @(negedge clk);
            valid    = 1'b0;
        end
    endtask

    // Send msg word by word; collect and check every emitted block.
    // hold < 0 selects a random block_ready_i delay per block.
    task automatic run_message(string tag, int max_gap, int hold);
        int nw;
        int blk_idx;
        nw      = (msg.size() + 7) / 8;
        blk_idx = 0;
        build_expected();
        for (int w = 0; w < nw; w++) begin
            int nb;
            nb = msg.size() - 8 * w;
            if (nb > 8) nb = 8;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            data = {$urandom, $urandom};
            for (int j = 0; j < nb; j++) data[63-8*j -: 8] = msg[8*w+j];
            padbytes = (w == nw - 1) ? 3'(8 - nb) : 3'($urandom);
            last     = (w == nw - 1);
            valid    = 1'b1;
            check_bit({tag, "_ready"}, ready, 1'b1);
            @(negedge clk);
            last = 1'b0;
            if ((w % 8 == 7) || (w == nw - 1)) begin
                int nblk;
                int h;
                nblk = (w == nw - 1) ? (exp_blocks.size() - blk_idx) : 1;
                for (int k = 0; k < nblk; k++) begin
                    // valid_i stays high with junk data; it must be ignored while sending.
                    valid = 1'b1;
                    data  = {$urandom, $urandom};
                    check_bit({tag, "_bvalid"}, bvalid, 1'b1);
                    check_bit({tag, "_ready_low"}, ready, 1'b0);
                    check_blk({tag, "_block"}, blk, exp_blocks[blk_idx]);
                    check_bit({tag, "_blast"}, blast, (blk_idx == exp_blocks.size() - 1));
                    h = (hold < 0) ? int'($urandom_range(3, 0)) : hold;
                    for (int c = 0; c < h; c++) begin
                        @(negedge clk);
                        check_bit({tag, "_hold_bvalid"}, bvalid, 1'b1);
                        check_bit({tag, "_hold_ready"}, ready, 1'b0);
                        check_blk({tag, "_hold_block"}, blk, exp_blocks[blk_idx]);
                    end
                    bready = 1'b1;
                    @(negedge clk);
                    bready = 1'b0;
                    blk_idx++;
                end
                valid = 1'b0;
                check_bit({tag, "_done_bvalid"}, bvalid, 1'b0);
                check_bit({tag, "_done_ready"}, ready, 1'b1);
            end else begin
                valid = 1'b0;
                check_bit({tag, "_no_bvalid"}, bvalid, 1'b0);
            end
        end
    endtask

    initial begin
        data     = '0;
        padbytes = '0;
        last     = 1'b0;
        valid    = 1'b0;
        bready   = 1'b0;
        reset    = 1'b0;

        // Reset state
        do_reset();
        check_bit("rst_ready", ready, 1'b1);
        check_bit("rst_bvalid", bvalid, 1'b0);
        check_bit("rst_blast", blast, 1'b0);
        check_blk("rst_block", blk, '0);

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        run_message("abc", 0, 0);

        // 55 bytes: single block
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'($urandom));
        run_message("len55", 0, -1);

        // 56 bytes: length spills into an extra block
        msg.delete();
        for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
        run_message("len56", 0, -1);

        // 64 bytes: marker goes to the top of the extra block
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
        run_message("len64", 1, -1);

        // Long stall with valid_i held high
        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
        run_message("stall", 0, 5);

        // Reset while sending: pending block is dropped
        drive_words(8);
        check_bit("midsend_bvalid", bvalid, 1'b1);
        do_reset();
        check_bit("midsend_rst_bvalid", bvalid, 1'b0);
        check_bit("midsend_rst_ready", ready, 1'b1);

        // Reset after 3 words, then "abc" again
        drive_words(3);
        do_reset();
        check_blk("midfill_rst_block", blk, '0);
        msg = '{8'h61, 8'h62, 8'h63};
        run_message("abc_after_rst", 0, 0);

        // Random messages back to back
        for (int m = 0; m < 25; m++) begin
            int len;
            len = int'($urandom_range(200, 1));
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            run_message("rand", 2, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
